ps_resp_fsm: RTL and testbench

//  Slave page scan / slave page response sequencer (Core 5.1 Vol2 PartB 8.3.1, 8.3.3).

---
 rtl/ps_resp_fsm_pkg.sv | 25 ++
 rtl/ps_tick_cnt.sv | 38 +++
 rtl/ps_resp_fsm.sv | 134 +++++++++++++
 tb/tb_ps_resp_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_resp_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps_resp_fsm_pkg
// Brief    : State encodings and default timing constants for the page scan
//            / slave page response sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ps_resp_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PS    = 3'd1,
        ST_TXID  = 3'd2,
        ST_WFHS  = 3'd3,
        ST_TXACK = 3'd4,
        ST_WPOLL = 3'd5,
        ST_CONN  = 3'd6
    } psState_t;

    localparam int HALF_US_DEF    = 312;
    localparam int NEWCONN_TO_DEF = 32;
    localparam int US_W           = 10;

endpackage
`default_nettype wire

// File: rtl/ps_tick_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ps_tick_cnt
// Brief    : Clearable, enabled, saturating tick counter with a terminal
//            count compare on the current value.
// Revision : 1.0 - initial release
// ============================================================================
module ps_tick_cnt #(
    parameter int W  = 10,
    parameter int TC = 1
) (
    input  logic clk_6M,
    input  logic rstz,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] c_TC  = W'(TC);
    localparam logic [W-1:0] c_ONE = W'(1);
    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tc = (r_cnt == c_TC);

endmodule
`default_nettype wire

// File: rtl/ps_resp_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ps_resp_fsm
// Brief    : Slave page scan / page response sequencer handing a new
//            connection to the link controller.
// Revision : 1.0 - initial release
// ============================================================================
module ps_resp_fsm
    import ps_resp_fsm_pkg::*;
#(
    parameter int HALF_US    = HALF_US_DEF,
    parameter int NEWCONN_TO = NEWCONN_TO_DEF,
    parameter int TO_W       = 6
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       tslot_p,
    input  logic       p_1us,
    input  logic       PageScanEnable,
    input  logic       PageScanWindow,
    input  logic       PageScanWindow_endp,
    input  logic       pagerespTO,
    input  logic       ps_corr_p,
    input  logic       fhs_ok_p,
    input  logic       fhs_err_p,
    input  logic       ackid_txdone_p,
    input  logic       poll_rx_p,
    input  logic       conn_exit,
    output logic       ps,
    output logic       spr,
    output logic       pstxid,
    output logic       ps_corr_halftslotdly_endp,
    output logic       fhs_ackid,
    output logic       newconnectionTO,
    output logic       conn_p,
    output logic       conns,
    output logic [2:0] ps_state
);

    psState_t r_state;
    psState_t w_next;
    logic     r_endp;
    logic     r_newConnTO;
    logic     r_connP;
    logic     w_endpSet;
    logic     w_toSet;
    logic     w_usTc;
    logic     w_slotTc;
    logic     w_usClr;
    logic     w_slotClr;

    assign w_usClr   = (r_state != ST_TXID)  || !PageScanEnable;
    assign w_slotClr = (r_state != ST_WPOLL) || !PageScanEnable;

    ps_tick_cnt #(.W(US_W), .TC(HALF_US - 1)) u_usCnt (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .clr    (w_usClr),
        .en     (p_1us),
        .tc     (w_usTc)
    );

    ps_tick_cnt #(.W(TO_W), .TC(NEWCONN_TO - 1)) u_slotCnt (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .clr    (w_slotClr),
        .en     (tslot_p),
        .tc     (w_slotTc)
    );

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state     <= ST_IDLE;
            r_endp      <= 1'b0;
            r_newConnTO <= 1'b0;
            r_connP     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_endp      <= w_endpSet;
            r_newConnTO <= w_toSet;
            r_connP     <= (w_next == ST_CONN) && (r_state != ST_CONN);
        end
    end

    // The ID-response end pulse is registered one cycle early so that it
    // lands on the final TXID cycle; its presence then drives the exit.
    always_comb begin
        w_next    = r_state;
        w_endpSet = 1'b0;
        w_toSet   = 1'b0;
        if (!PageScanEnable && (r_state != ST_CONN)) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (PageScanWindow) w_next = ST_PS;
                ST_PS: begin
                    if (ps_corr_p && PageScanWindow) w_next = ST_TXID;
                    else if (PageScanWindow_endp)    w_next = ST_IDLE;
                end
                ST_TXID: begin
                    if (r_endp)                 w_next    = ST_WFHS;
                    else if (p_1us && w_usTc)   w_endpSet = 1'b1;
                end
                ST_WFHS: begin
                    if (fhs_ok_p)        w_next = ST_TXACK;
                    else if (pagerespTO) w_next = PageScanWindow ? ST_PS : ST_IDLE;
                end
                ST_TXACK: if (ackid_txdone_p) w_next = ST_WPOLL;
                ST_WPOLL: begin
                    if (poll_rx_p) begin
                        w_next = ST_CONN;
                    end else if (tslot_p && w_slotTc) begin
                        w_toSet = 1'b1;
                        w_next  = PageScanWindow ? ST_PS : ST_IDLE;
                    end
                end
                ST_CONN:  if (conn_exit) w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    assign ps                        = (r_state == ST_PS);
    assign spr                       = (r_state inside {ST_TXID, ST_WFHS, ST_TXACK, ST_WPOLL});
    assign pstxid                    = (r_state == ST_TXID);
    assign ps_corr_halftslotdly_endp = r_endp;
    assign fhs_ackid                 = (r_state == ST_TXACK);
    assign newconnectionTO           = r_newConnTO;
    assign conn_p                    = r_connP;
    assign conns                     = (r_state == ST_CONN);
    assign ps_state                  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ps_resp_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_resp_fsm
// Brief    : Self-checking bench for ps_resp_fsm (vectors, directed
//            sequences and randomized run against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_resp_fsm;

    localparam int HALF_US    = 312;
    localparam int NEWCONN_TO = 32;
    localparam int TO_W       = 6;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    logic tslot_p = 1'b0, p_1us = 1'b0, PageScanEnable = 1'b0, PageScanWindow = 1'b0;
    logic PageScanWindow_endp = 1'b0, pagerespTO = 1'b0, ps_corr_p = 1'b0, fhs_ok_p = 1'b0;
    logic fhs_err_p = 1'b0, ackid_txdone_p = 1'b0, poll_rx_p = 1'b0, conn_exit = 1'b0;
    logic ps, spr, pstxid, ps_corr_halftslotdly_endp, fhs_ackid, newconnectionTO, conn_p, conns;
    logic [2:0] ps_state;

    always #5 clk_6M = ~clk_6M;

    ps_resp_fsm #(.HALF_US(HALF_US), .NEWCONN_TO(NEWCONN_TO), .TO_W(TO_W)) dut (
        .clk_6M                    (clk_6M),
        .rstz                      (rstz),
        .tslot_p                   (tslot_p),
        .p_1us                     (p_1us),
        .PageScanEnable            (PageScanEnable),
        .PageScanWindow            (PageScanWindow),
        .PageScanWindow_endp       (PageScanWindow_endp),
        .pagerespTO                (pagerespTO),
        .ps_corr_p                 (ps_corr_p),
        .fhs_ok_p                  (fhs_ok_p),
        .fhs_err_p                 (fhs_err_p),
        .ackid_txdone_p            (ackid_txdone_p),
        .poll_rx_p                 (poll_rx_p),
        .conn_exit                 (conn_exit),
        .ps                        (ps),
        .spr                       (spr),
        .pstxid                    (pstxid),
        .ps_corr_halftslotdly_endp (ps_corr_halftslotdly_endp),
        .fhs_ackid                 (fhs_ackid),
        .newconnectionTO           (newconnectionTO),
        .conn_p                    (conn_p),
        .conns                     (conns),
        .ps_state                  (ps_state)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: state numbers as listed for the block, plus elapsed
    // us/slot tick counts and the pulses expected in the current cycle.
    int mSt = 0, mUs = 0, mSlot = 0;
    bit mArm = 0, mTo = 0, mConn = 0;

    typedef struct {
        logic       en;
        logic       win;
        logic       wendp;
        logic       corr;
        logic [2:0] expSt;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [10:0] actVec();
        return {ps, spr, pstxid, ps_corr_halftslotdly_endp, fhs_ackid,
                newconnectionTO, conn_p, conns, ps_state};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        int  nxt;
        bit  armN, toN;
        nxt  = mSt;
        armN = 0;
        toN  = 0;
        if (!rstz) begin
            mSt = 0; mUs = 0; mSlot = 0; mArm = 0; mTo = 0; mConn = 0;
            return;
        end
        if (!PageScanEnable && mSt != 6) begin
            nxt = 0;
        end else begin
            case (mSt)
                0: if (PageScanWindow) nxt = 1;
                1: if (ps_corr_p && PageScanWindow) begin nxt = 2; mUs = 0; end
                   else if (PageScanWindow_endp) nxt = 0;
                2: if (mArm) nxt = 3;
                   else if (p_1us) begin
                       mUs++;
                       if (mUs == HALF_US) armN = 1;
                   end
                3: if (fhs_ok_p) nxt = 4;
                   else if (pagerespTO) nxt = PageScanWindow ? 1 : 0;
                4: if (ackid_txdone_p) begin nxt = 5; mSlot = 0; end
                5: if (poll_rx_p) nxt = 6;
                   else if (tslot_p) begin
                       mSlot++;
                       if (mSlot == NEWCONN_TO) begin toN = 1; nxt = PageScanWindow ? 1 : 0; end
                   end
                6: if (conn_exit) nxt = 0;
                default: nxt = 0;
            endcase
        end
        mConn = (nxt == 6) && (mSt != 6);
        mSt   = nxt;
        mArm  = armN;
        mTo   = toN;
    endtask

    function automatic logic [10:0] expVec();
        logic [2:0] s;
        s = 3'(mSt);
        return {mSt == 1, (mSt >= 2) && (mSt <= 5), mSt == 2, logic'(mArm), mSt == 4,
                logic'(mTo), logic'(mConn), mSt == 6, s};
    endfunction

    task automatic step();
        @(posedge clk_6M);
        modelStep();
        #1;
        chk("model_cycle", 32'(actVec()), 32'(expVec()));
    endtask

    task automatic clrPulses();
        tslot_p = 0; p_1us = 0; PageScanWindow_endp = 0; pagerespTO = 0; ps_corr_p = 0;
        fhs_ok_p = 0; fhs_err_p = 0; ackid_txdone_p = 0; poll_rx_p = 0; conn_exit = 0;
    endtask

    task automatic goTxid();
        clrPulses();
        PageScanEnable = 0; step();
        PageScanEnable = 1; PageScanWindow = 1; step();
        ps_corr_p = 1; step();
        ps_corr_p = 0;
    endtask

    task automatic runTxid(output int ticks, output logic sawTx);
        ticks = 0;
        sawTx = 0;
        for (int i = 0; i < 1000; i++) begin
            p_1us = 1; step(); ticks++;
            if (ps_corr_halftslotdly_endp) begin sawTx = pstxid; break; end
        end
        p_1us = 0;
    endtask

    task automatic goWpoll();
        int   t;
        logic s;
        goTxid(); runTxid(t, s); step();
        fhs_ok_p = 1; step(); fhs_ok_p = 0;
        ackid_txdone_p = 1; step(); ackid_txdone_p = 0;
    endtask

    task automatic wpollTimeout(input logic win);
        goWpoll();
        PageScanWindow = win;
        for (int i = 0; i < NEWCONN_TO; i++) begin
            tslot_p = 1; step();
            if (i == NEWCONN_TO - 2) chk("wpoll_no_early_to", 32'(newconnectionTO), 32'd0);
        end
        tslot_p = 0;
        chk("wpoll_to_pulse", 32'(newconnectionTO), 32'd1);
        chk("wpoll_to_state", 32'(ps_state), win ? 32'd1 : 32'd0);
        step();
        chk("wpoll_to_single", 32'(newconnectionTO), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ticks, endps;
        logic sawTx;

        repeat (3) @(posedge clk_6M);
        #1;
        chk("reset_outputs", 32'(actVec()), 32'd0);
        rstz = 1;

        // Vectors from IDLE: window gating, window end, corr/endp collision.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        for (int i = 0; i < 8; i++) begin
            PageScanEnable = vecs[i].en; PageScanWindow = vecs[i].win;
            PageScanWindow_endp = vecs[i].wendp; ps_corr_p = vecs[i].corr;
            step();
            chk($sformatf("vec%0d_state", i), 32'(ps_state), 32'(vecs[i].expSt));
        end
        clrPulses();

        // TXID length and end pulse, then WFHS.
        goTxid();
        chk("txid_entered", 32'(pstxid), 32'd1);
        runTxid(ticks, sawTx);
        chk("txid_ticks", 32'(ticks), 32'(HALF_US));
        chk("endp_with_pstxid", 32'(sawTx), 32'd1);
        step();
        chk("wfhs_spr", 32'({spr, ps_state}), 32'({1'b1, 3'd3}));
        chk("endp_single", 32'(ps_corr_halftslotdly_endp), 32'd0);

        // FHS error is ignored; page response timeout returns to PS.
        fhs_err_p = 1; step(); fhs_err_p = 0;
        chk("wfhs_err_stay", 32'(ps_state), 32'd3);
        pagerespTO = 1; step(); pagerespTO = 0;
        chk("wfhs_to_ps", 32'({ps, spr}), 32'b10);

        // Full connection sequence.
        goTxid(); runTxid(ticks, sawTx); step();
        fhs_ok_p = 1; step(); fhs_ok_p = 0;
        chk("txack_fhs_ackid", 32'(fhs_ackid), 32'd1);
        pagerespTO = 1; step(); pagerespTO = 0;
        chk("txack_ignore_to", 32'(ps_state), 32'd4);
        ackid_txdone_p = 1; step(); ackid_txdone_p = 0;
        chk("wpoll_entered", 32'(ps_state), 32'd5);
        for (int i = 0; i < 5; i++) begin
            tslot_p = 1; step(); tslot_p = 0; step();
        end
        poll_rx_p = 1; tslot_p = 1; step(); poll_rx_p = 0; tslot_p = 0;
        chk("conn_pulse", 32'({conn_p, conns}), 32'b11);
        step();
        chk("conn_p_single", 32'({conn_p, conns}), 32'b01);
        PageScanEnable = 0; step();
        chk("conn_ignore_en", 32'(conns), 32'd1);
        PageScanEnable = 1; conn_exit = 1; step(); conn_exit = 0;
        chk("conn_exit_idle", 32'(ps_state), 32'd0);

        // WPOLL timeout, both window polarities.
        wpollTimeout(1'b1);
        wpollTimeout(1'b0);

        // Poll coinciding with the timeout tick wins.
        goWpoll();
        for (int i = 0; i < NEWCONN_TO - 1; i++) begin tslot_p = 1; step(); end
        poll_rx_p = 1; step(); poll_rx_p = 0; tslot_p = 0;
        chk("poll_beats_to", 32'({newconnectionTO, conn_p, conns}), 32'b011);
        PageScanEnable = 1; conn_exit = 1; step(); conn_exit = 0;

        // Enable dropped in WFHS.
        goTxid(); runTxid(ticks, sawTx); step();
        PageScanEnable = 0; step();
        chk("en_low_idle", 32'(actVec()), 32'd0);
        PageScanEnable = 1;

        // Asynchronous reset mid-TXID, then no stale end pulse afterwards.
        goTxid();
        for (int i = 0; i < HALF_US - 2; i++) begin p_1us = 1; step(); end
        #2;
        rstz = 0;
        #1;
        chk("async_rst", 32'(actVec()), 32'd0);
        step();
        #2;
        rstz = 1;
        PageScanWindow = 0;
        endps = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ps_corr_halftslotdly_endp) endps++;
        end
        p_1us = 0;
        chk("no_endp_after_rst", 32'(endps), 32'd0);

        // Randomized run against the model.
        PageScanEnable = 1;
        for (int c = 0; c < 20000 && failures < 20; c++) begin
            PageScanEnable      = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 99) == 0) PageScanWindow = ~PageScanWindow;
            PageScanWindow_endp = ($urandom_range(0, 49) == 0);
            ps_corr_p           = ($urandom_range(0, 19) == 0);
            p_1us               = ($urandom_range(0, 7) != 0);
            tslot_p             = ($urandom_range(0, 1) == 0);
            fhs_ok_p            = ($urandom_range(0, 39) == 0);
            fhs_err_p           = ($urandom_range(0, 9) == 0);
            pagerespTO          = ($urandom_range(0, 299) == 0);
            ackid_txdone_p      = ($urandom_range(0, 19) == 0);
            poll_rx_p           = ($urandom_range(0, 79) == 0);
            conn_exit           = ($urandom_range(0, 99) == 0);
            step();
        end
        clrPulses();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
